updown_counter_gen2: RTL and testbench

Parametrised synchronous up/down counter with asynchronous active-low clear. It generalises the basic 3-bit up/down counter with configurable width, modulus, step size, wrap or saturate mode, parallel load, synchronous clear, and boundary/event flags. It is intended as a drop-in counting primitive for control paths and synthesis regression designs.

---
 rtl/updown_counter_pkg.sv | 30 +++
 rtl/updown_next_val.sv | 89 ++++++++
 rtl/updown_counter_gen2.sv | 89 ++++++++
 tb/tb_updown_counter_gen2.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter: mode constants
// and the operation selected on each clock edge.
package updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  // Resolve the control inputs into one operation, highest priority first.
  // up and down together deliberately mean hold, not up-wins.
  function automatic op_e decode_op(input logic sync_clr, input logic load,
                                    input logic up, input logic down);
    op_e op;
    if (sync_clr)          op = OP_CLR;
    else if (load)         op = OP_LOAD;
    else if (up && down)   op = OP_HOLD;
    else if (up)           op = OP_UP;
    else if (down)         op = OP_DOWN;
    else                   op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/updown_next_val.sv
// Combinational next-count datapath. Given the current count and the decoded
// operation it returns the next count (always within 0..MAX_VAL) plus flags
// saying whether a step wrapped, saturated, or a load value was clamped.
module updown_next_val
  import updown_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int STEP      = 1,
  parameter int SATURATE  = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_next,
  output logic             wrapped,
  output logic             saturated,
  output logic             clamped
);

  // One extra bit keeps q + STEP and q + MAX_VAL + 1 free of truncation.
  localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_X   = MAX_X + 1'b1;
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic [WIDTH:0] q_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] wrap_x;

  assign q_x = {1'b0, q};

  // Compute the next count and the event indicators for the chosen operation.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    q_next    = q;
    wrapped   = 1'b0;
    saturated = 1'b0;
    clamped   = 1'b0;
    sum_x     = q_x + STEP_X;
    wrap_x    = '0;

    unique case (op)
      OP_CLR: q_next = RESET_W;

      OP_LOAD: begin
        if ({1'b0, load_val} > MAX_X) begin
          q_next  = MAX_W;
          clamped = 1'b1;
        end else begin
          q_next = load_val;
        end
      end

      OP_UP: begin
        if (sum_x <= MAX_X) begin
          q_next = sum_x[WIDTH-1:0];
        end else if (SATURATE == MODE_SAT) begin
          q_next    = MAX_W;
          saturated = 1'b1;
        end else begin
          wrap_x  = sum_x - MOD_X;
          q_next  = wrap_x[WIDTH-1:0];
          wrapped = 1'b1;
        end
      end

      OP_DOWN: begin
        if (q_x >= STEP_X) begin
          q_next = q - STEP_W;
        end else if (SATURATE == MODE_SAT) begin
          q_next    = '0;
          saturated = 1'b1;
        end else begin
          wrap_x  = q_x + MOD_X - STEP_X;
          q_next  = wrap_x[WIDTH-1:0];
          wrapped = 1'b1;
        end
      end

      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/updown_counter_gen2.sv
// Parametrised up/down counter with asynchronous clear, synchronous clear,
// clamped parallel load, wrap or saturate mode, boundary flags, registered
// overflow/underflow pulses and a sticky error flag.
module updown_counter_gen2
  import updown_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int STEP      = 1,
  parameter int SATURATE  = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  op_e              op;
  logic [WIDTH-1:0] q_next;
  logic             wrapped;
  logic             saturated;
  logic             clamped;
  logic             step_evt;
  logic             ovf_next;
  logic             unf_next;

  // Decode the control inputs into a single prioritised operation.
  always_comb begin
    op = decode_op(sync_clr, load, up, down);
  end

  updown_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE),
    .RESET_VAL(RESET_VAL)
  ) u_next_val (
    .q        (q),
    .op       (op),
    .load_val (load_val),
    .q_next   (q_next),
    .wrapped  (wrapped),
    .saturated(saturated),
    .clamped  (clamped)
  );

  // A step event is a wrap or a clamp at a boundary; its direction picks the flag.
  assign step_evt = wrapped | saturated;
  assign ovf_next = step_evt && (op == OP_UP);
  assign unf_next = step_evt && (op == OP_DOWN);

  // Count register and event flags; clr_n forces the reset state immediately.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q   <= RESET_W;
      ovf <= 1'b0;
      unf <= 1'b0;
      err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      q   <= q_next;
      ovf <= ovf_next;
      unf <= unf_next;
      if (op == OP_CLR)
        err <= 1'b0;
      else if (ovf_next || unf_next || clamped)
        err <= 1'b1;
    end
  end

  assign at_max = (q == MAX_W);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_gen2.sv
// Testbench for updown_counter_gen2: seven differently configured instances
// share one stimulus stream and are compared every cycle against an
// arithmetic reference model, with directed steps for the named scenarios.
module tb_updown_counter_gen2;

  localparam int NDUT = 7;

  // Configuration table: 0 W8 default, 1 W3 default, 2 W3 M5 S2 wrap,
  // 3 W3 S2 sat, 4 W3 M5, 5 W4 M11 S3 sat R2, 6 W1 R1.
  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      5: return 4;
      6: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_max(input int i);
    case (i)
      0: return 255;
      2: return 5;
      4: return 5;
      5: return 11;
      6: return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_step(input int i);
    case (i)
      2: return 2;
      3: return 2;
      5: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_sat(input int i);
    return (i == 3 || i == 5) ? 1 : 0;
  endfunction

  function automatic int cfg_rst(input int i);
    case (i)
      5: return 2;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  logic       clk;
  logic       clr_n;
  logic       sync_clr;
  logic       load;
  logic [7:0] load_val;
  logic       up;
  logic       down;

  logic [7:0] obs_q   [NDUT];
  logic       obs_max [NDUT];
  logic       obs_min [NDUT];
  logic       obs_ovf [NDUT];
  logic       obs_unf [NDUT];
  logic       obs_err [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = cfg_w(g);
    logic [W-1:0] q;
    logic         at_max;
    logic         at_min;
    logic         ovf;
    logic         unf;
    logic         err;

    updown_counter_gen2 #(
      .WIDTH    (W),
      .MAX_VAL  (cfg_max(g)),
      .STEP     (cfg_step(g)),
      .SATURATE (cfg_sat(g)),
      .RESET_VAL(cfg_rst(g))
    ) dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .sync_clr(sync_clr),
      .load    (load),
      .load_val(load_val[W-1:0]),
      .up      (up),
      .down    (down),
      .q       (q),
      .at_max  (at_max),
      .at_min  (at_min),
      .ovf     (ovf),
      .unf     (unf),
      .err     (err)
    );

    assign obs_q[g]   = 8'(q);
    assign obs_max[g] = at_max;
    assign obs_min[g] = at_min;
    assign obs_ovf[g] = ovf;
    assign obs_unf[g] = unf;
    assign obs_err[g] = err;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, one entry per instance.
  int mq [NDUT];
  bit mo [NDUT];
  bit mu [NDUT];
  bit me [NDUT];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      mq[i] = cfg_rst(i);
      mo[i] = 1'b0;
      mu[i] = 1'b0;
      me[i] = 1'b0;
    end
  endtask

  // Apply the counting rules to every model entry for one rising edge.
  task automatic model_edge();
    if (!clr_n) return;
    for (int i = 0; i < NDUT; i++) begin
      int mx = cfg_max(i);
      int st = cfg_step(i);
      int lv = int'(load_val) & ((1 << cfg_w(i)) - 1);
      mo[i] = 1'b0;
      mu[i] = 1'b0;
      if (sync_clr) begin
        mq[i] = cfg_rst(i);
        me[i] = 1'b0;
      end else if (load) begin
        if (lv > mx) begin
          mq[i] = mx;
          me[i] = 1'b1;
        end else begin
          mq[i] = lv;
        end
      end else if (up && !down) begin
        if (mq[i] + st <= mx) mq[i] = mq[i] + st;
        else begin
          mq[i] = cfg_sat(i) != 0 ? mx : (mq[i] + st) % (mx + 1);
          mo[i] = 1'b1;
          me[i] = 1'b1;
        end
      end else if (down && !up) begin
        if (mq[i] >= st) mq[i] = mq[i] - st;
        else begin
          mq[i] = cfg_sat(i) != 0 ? 0 : (mq[i] - st + mx + 1) % (mx + 1);
          mu[i] = 1'b1;
          me[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d_q", i),      obs_q[i],         8'(mq[i]));
      check($sformatf("d%0d_at_max", i), 8'(obs_max[i]),   8'(mq[i] == cfg_max(i)));
      check($sformatf("d%0d_at_min", i), 8'(obs_min[i]),   8'(mq[i] == 0));
      check($sformatf("d%0d_ovf", i),    8'(obs_ovf[i]),   8'(mo[i]));
      check($sformatf("d%0d_unf", i),    8'(obs_unf[i]),   8'(mu[i]));
      check($sformatf("d%0d_err", i),    8'(obs_err[i]),   8'(me[i]));
    end
  endtask

  // One rising edge: update the model at the edge, sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    clr_n    = 1'b1;
    sync_clr = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    up       = 1'b0;
    down     = 1'b0;

    // Reset and release.
    #2 clr_n = 1'b0;
    model_reset();
    #1;
    check("t1_reset_q", obs_q[1], 8'd0);
    check("reset_q_rv2", obs_q[5], 8'd2);
    check_model();
    tick();
    clr_n = 1'b1;

    // Scenario 1: up twice, down once, idle once on the 3-bit default counter.
    up = 1'b1;
    tick();
    check("t1_up1", obs_q[1], 8'd1);
    tick();
    check("t1_up2", obs_q[1], 8'd2);
    up = 1'b0; down = 1'b1;
    tick();
    check("t1_down", obs_q[1], 8'd1);
    down = 1'b0;
    tick();
    check("t1_idle", obs_q[1], 8'd1);

    // Scenario 2: MAX 5, STEP 2 wrap.
    load = 1'b1; load_val = 8'd4;
    tick();
    check("t2_load", obs_q[2], 8'd4);
    load = 1'b0; up = 1'b1;
    tick();
    check("t2_wrap_q", obs_q[2], 8'd0);
    check("t2_ovf", 8'(obs_ovf[2]), 8'd1);
    check("t2_err", 8'(obs_err[2]), 8'd1);
    up = 1'b0; down = 1'b1;
    tick();
    check("t2_down_q", obs_q[2], 8'd4);
    check("t2_unf", 8'(obs_unf[2]), 8'd1);
    check("t2_ovf_clr", 8'(obs_ovf[2]), 8'd0);
    down = 1'b0;
    tick();
    check("t2_unf_clr", 8'(obs_unf[2]), 8'd0);
    check("t2_err_sticky", 8'(obs_err[2]), 8'd1);

    // Scenario 3: saturate mode, STEP 2.
    load = 1'b1; load_val = 8'd6;
    tick();
    check("t3_load", obs_q[3], 8'd6);
    load = 1'b0; up = 1'b1;
    tick();
    check("t3_sat_q", obs_q[3], 8'd7);
    check("t3_ovf", 8'(obs_ovf[3]), 8'd1);
    tick();
    check("t3_sat_q2", obs_q[3], 8'd7);
    check("t3_ovf2", 8'(obs_ovf[3]), 8'd1);
    up = 1'b0; load = 1'b1; load_val = 8'd1;
    tick();
    check("t3_load1", obs_q[3], 8'd1);
    load = 1'b0; down = 1'b1;
    tick();
    check("t3_floor_q", obs_q[3], 8'd0);
    check("t3_unf", 8'(obs_unf[3]), 8'd1);
    check("t3_at_min", 8'(obs_min[3]), 8'd1);

    // Scenario 4: up and down together hold.
    down = 1'b0; load = 1'b1; load_val = 8'hF0;
    tick();
    check("t4_load", obs_q[0], 8'hF0);
    load = 1'b0; up = 1'b1; down = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_hold_q", obs_q[0], 8'hF0);
      check("t4_ovf", 8'(obs_ovf[0]), 8'd0);
      check("t4_unf", 8'(obs_unf[0]), 8'd0);
    end
    up = 1'b0; down = 1'b0;

    // Scenario 5: clamped load then synchronous clear.
    load = 1'b1; load_val = 8'd7;
    tick();
    check("t5_clamp_q", obs_q[4], 8'd5);
    check("t5_at_max", 8'(obs_max[4]), 8'd1);
    check("t5_err", 8'(obs_err[4]), 8'd1);
    load = 1'b0; sync_clr = 1'b1;
    tick();
    check("t5_clr_q", obs_q[4], 8'd0);
    check("t5_clr_err", 8'(obs_err[4]), 8'd0);
    sync_clr = 1'b0;

    // Scenario 6: asynchronous clear mid-count.
    up = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("t6_count", obs_q[1], 8'd3);
    @(negedge clk);
    clr_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_q", obs_q[1], 8'd0);
    check("t6_async_rv", obs_q[5], 8'd2);
    check_model();
    tick();
    tick();
    check("t6_edges_ignored", obs_q[1], 8'd0);
    clr_n = 1'b1;
    tick();
    check("t6_first_up", obs_q[1], 8'd1);
    check("t6_first_up_rv", obs_q[5], 8'd5);
    up = 1'b0;

    // Randomised phase with occasional asynchronous clears.
    for (int n = 0; n < 400; n++) begin
      sync_clr = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 8'($urandom);
      up       = 1'($urandom);
      down     = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        clr_n = 1'b0;
        model_reset();
        #1;
        check_model();
        tick();
        clr_n = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
